damage_arbiter: RTL and testbench
=================================

// Module: damage_arbiter
// PURPOSE
//  Shares the single damage coprocessor between the two players' attack sources.
//  Grants one attack word at a time and drives it into the coprocessor.
//  Captures the damage the coprocessor registers and adds it to the victim's percent,
//  saturating at MAX_PERCENT. The victim is always the other player.
//  Enforces a per-victim invulnerability window after every applied hit.
// PARAMETERS
//  COOLDOWN     30   cycles a victim ignores further hits after damage is applied
//  MAX_PERCENT  999  saturation ceiling for percent_p1/percent_p2 (must fit 10 bits)
//  CNT_W        8    width of the cooldown counters (must hold COOLDOWN)
// PORTS
//  clock         in   1   system clock
//  reset         in   1   synchronous, active-high
//  req_p1        in   1   P1 attack request (level)
//  attack_p1     in   32  P1 attack word: bit0 connect, bit5 a, bit6 up b, bit7 down b, bit8/9 side b, bit10 b
//  req_p2        in   1   P2 attack request (level)
//  attack_p2     in   32  P2 attack word, same encoding
//  grant_p1      out  1   one-cycle pulse: P1 request accepted
//  grant_p2      out  1   one-cycle pulse: P2 request accepted
//  cp_attack     out  32  registered attack word to the coprocessor attack input
//  cp_damage     in   32  coprocessor damage output
//  clear_percent in   1   synchronous clear of both percents and both cooldowns
//  percent_p1    out  10  P1 accumulated damage
//  percent_p2    out  10  P2 accumulated damage
//  hit_p1        out  1   one-cycle pulse: damage applied to P1
//  hit_p2        out  1   one-cycle pulse: damage applied to P2
//  busy          out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cooldowns 0, rr pointer set so that P1 wins the next tie.
//  FSM states: IDLE -> ISSUE -> CAPTURE -> IDLE. Every grant takes exactly 3 cycles.
//  IDLE (cycle T0), with any request pending:
//   - Pick the winner. A single requester wins outright. If both request, the player
//     not granted last wins. Update the rr pointer.
//   - Register the winner's grant pulse (high in T1).
//   - Compute go = attack[0] & |attack[10:5] & (victim cooldown == 0).
//     cp_attack <= go ? winner attack : 0. Latch go and the victim id. Next state ISSUE.
//  ISSUE (T1): cp_attack is held, and the coprocessor registers damage at the end of T1.
//   Next state CAPTURE.
//  CAPTURE (T2): cp_damage is valid.
//   - If go: victim percent <= min(percent + cp_damage, MAX_PERCENT). If cp_damage[31:10]
//     is nonzero, the result is MAX_PERCENT. Also load victim cooldown <= COOLDOWN and
//     register the victim's hit pulse (high in T3).
//   - If !go: no percent change, no hit.
//   - In both cases cp_attack <= 0 and the next state is IDLE.
//  Latency: request sampled in T0 -> grant visible in T1 -> percent/hit visible in T3.
//  A request is never dropped. A request held after its grant counts as a new request,
//  so a continuously held req rearbitrates every 3 cycles.
//  Cooldown counters decrement by 1 each cycle while nonzero. A reload in CAPTURE
//  overrides the decrement.
//  Blocked or invalid attacks still complete the handshake (grant pulse, 3 cycles).
//  clear_percent: zeroes both percents and both cooldowns. It wins over a same-cycle
//  CAPTURE update. It does not affect FSM state, grants or the rr pointer.
//  A hit pulse is still issued for that capture.
//  Reset mid-operation: abort immediately to the reset state; no grant or hit pulse follows.
//  cp_attack is 0 whenever the state is IDLE.
// TESTING
//  1. Assert reset 2 cycles -> all outputs 0, busy 0; first tie goes to P1.
//  2. req_p1 with attack_p1=0x21 -> grant_p1 in T1, cp_attack=0x21 in T1,
//     percent_p2=5 and hit_p2 in T3, busy low in T3.
//  3. req_p1 and req_p2 held, P1 attack=0x41, P2 attack=0x81 -> grants alternate
//     P1,P2,P1 every 3 cycles; percent_p2 reaches 20, then percent_p1 reaches 15.
//  4. COOLDOWN=4: P1 0x401 twice back-to-back -> percent_p2=10, second attack granted
//     with cp_attack=0 and no hit_p2; a third attack after 4 idle cycles makes percent_p2=20.
//  5. MAX_PERCENT=40, COOLDOWN=0: P2 0x101 twice -> percent_p1 30 then 40 (not 60).
//     clear_percent -> 0.
//  6. P1 attack 0x20 (bit0 clear) -> grant_p1 pulses, cp_attack=0, no hit.
//     Reset asserted in ISSUE -> IDLE next cycle, no hit, percents 0.

Source files
------------

// File: rtl/damage_arbiter_if.sv
// Bundle carrying the attack requests, grants, coprocessor link and per-player
// percent/hit status between the two attack sources and the damage arbiter.
interface damage_arbiter_if;
  logic        req_p1;
  logic [31:0] attack_p1;
  logic        req_p2;
  logic [31:0] attack_p2;
  logic        grant_p1;
  logic        grant_p2;
  logic [31:0] cp_attack;
  logic [31:0] cp_damage;
  logic        clear_percent;
  logic [9:0]  percent_p1;
  logic [9:0]  percent_p2;
  logic        hit_p1;
  logic        hit_p2;
  logic        busy;

  // Request side plus the coprocessor damage return.
  modport master (
    output req_p1, attack_p1, req_p2, attack_p2, cp_damage, clear_percent,
    input  grant_p1, grant_p2, cp_attack, percent_p1, percent_p2,
           hit_p1, hit_p2, busy
  );

  // The arbiter itself.
  modport slave (
    input  req_p1, attack_p1, req_p2, attack_p2, cp_damage, clear_percent,
    output grant_p1, grant_p2, cp_attack, percent_p1, percent_p2,
           hit_p1, hit_p2, busy
  );
endinterface

// File: rtl/damage_arbiter.sv
// Shares one damage coprocessor between two players' attack sources. Each grant
// runs a fixed three-cycle IDLE -> ISSUE -> CAPTURE sequence; the damage that
// comes back is added to the other player's percent (saturating), after which
// that victim ignores further hits for COOLDOWN cycles.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting; arbitrates and registers grant/cp_attack when a req is up
//  ISSUE   | cp_attack held; coprocessor registers its damage this cycle
//  CAPTURE | cp_damage valid; apply to victim if the attack was accepted
module damage_arbiter #(
  parameter int COOLDOWN    = 30,
  parameter int MAX_PERCENT = 999,
  parameter int CNT_W       = 8
) (
  input logic             clock,
  input logic             reset,
  damage_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  localparam logic [10:0]      MAX_W   = 11'(MAX_PERCENT);
  localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN);

  state_t           state, state_nxt;
  logic             prio_p2;      // 1: P2 wins the next tie
  logic             go_q;         // latched "attack is applied" flag
  logic             victim_p1;    // latched victim of the current grant
  logic [CNT_W-1:0] cd_p1, cd_p2;
  logic [9:0]       pct_p1, pct_p2;

  logic             any_req, win_p2, go;
  logic [31:0]      win_attack;
  logic [CNT_W-1:0] victim_cd;
  logic [9:0]       victim_pct, sat_pct;
  logic [10:0]      sum;
  logic             do_arb, do_capture;

  // Winner selection, accept decision and saturating percent update.
  always_comb begin
    any_req    = bus.req_p1 | bus.req_p2;
    win_p2     = bus.req_p2 & (~bus.req_p1 | prio_p2);
    win_attack = win_p2 ? bus.attack_p2 : bus.attack_p1;
    victim_cd  = win_p2 ? cd_p1 : cd_p2;
    go         = win_attack[0] & (|win_attack[10:5]) & (victim_cd == '0);
    victim_pct = victim_p1 ? pct_p1 : pct_p2;
    sum        = {1'b0, victim_pct} + {1'b0, bus.cp_damage[9:0]};
    if ((|bus.cp_damage[31:10]) || (sum > MAX_W)) sat_pct = MAX_W[9:0];
    else                                          sat_pct = sum[9:0];
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy flag and datapath strobes.
  always_comb begin
    bus.busy   = (state != IDLE);
    do_arb     = (state == IDLE) && any_req;
    do_capture = (state == CAPTURE);
  end

  // Grant/hit pulses, coprocessor word, percents and cooldown timers.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.grant_p1  <= 1'b0;
      bus.grant_p2  <= 1'b0;
      bus.hit_p1    <= 1'b0;
      bus.hit_p2    <= 1'b0;
      bus.cp_attack <= '0;
      prio_p2       <= 1'b0;
      go_q          <= 1'b0;
      victim_p1     <= 1'b0;
      cd_p1         <= '0;
      cd_p2         <= '0;
      pct_p1        <= '0;
      pct_p2        <= '0;
    end else begin
      bus.grant_p1 <= 1'b0;
      bus.grant_p2 <= 1'b0;
      bus.hit_p1   <= 1'b0;
      bus.hit_p2   <= 1'b0;
      if (cd_p1 != '0) cd_p1 <= cd_p1 - 1'b1;
      if (cd_p2 != '0) cd_p2 <= cd_p2 - 1'b1;

      if (do_arb) begin
        bus.grant_p1  <= ~win_p2;
        bus.grant_p2  <= win_p2;
        prio_p2       <= ~win_p2;
        go_q          <= go;
        victim_p1     <= win_p2;
        bus.cp_attack <= go ? win_attack : '0;
      end

      if (do_capture) begin
        bus.cp_attack <= '0;
        if (go_q) begin
          if (victim_p1) begin
            pct_p1     <= sat_pct;
            cd_p1      <= CD_LOAD;
            bus.hit_p1 <= 1'b1;
          end else begin
            pct_p2     <= sat_pct;
            cd_p2      <= CD_LOAD;
            bus.hit_p2 <= 1'b1;
          end
        end
      end

      // Clear beats a same-cycle capture update; the hit pulse still goes out.
      if (bus.clear_percent) begin
        pct_p1 <= '0;
        pct_p2 <= '0;
        cd_p1  <= '0;
        cd_p2  <= '0;
      end
    end
  end

  assign bus.percent_p1 = pct_p1;
  assign bus.percent_p2 = pct_p2;
endmodule

// File: tb/tb_damage_arbiter.sv
// Scoreboard bench for damage_arbiter. Instance A: COOLDOWN=4, MAX_PERCENT=999.
// Instance B: COOLDOWN=0, MAX_PERCENT=40. Each bus has a small coprocessor model.
module tb_damage_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  damage_arbiter_if bus_a ();
  damage_arbiter_if bus_b ();

  damage_arbiter #(.COOLDOWN(4), .MAX_PERCENT(999), .CNT_W(8)) dut_a (
    .clock(clk), .reset(rst), .bus(bus_a));
  damage_arbiter #(.COOLDOWN(0), .MAX_PERCENT(40), .CNT_W(8)) dut_b (
    .clock(clk), .reset(rst), .bus(bus_b));

  typedef struct packed { logic p2; logic [31:0] cp;  } gexp_t;
  typedef struct packed { logic p2; logic [9:0]  pct; } hexp_t;

  gexp_t gqa[$], gqb[$];
  hexp_t hqa[$], hqb[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // Coprocessor damage table: a=5, up b=10, down b=15, bit8 side b=30,
  // bit9 side b=huge (exercises the upper-bit saturation), b=10.
  function automatic logic [31:0] dmg(input logic [31:0] a);
    logic [31:0] d;
    d = 32'd0;
    if (a[5])  d = d + 32'd5;
    if (a[6])  d = d + 32'd10;
    if (a[7])  d = d + 32'd15;
    if (a[8])  d = d + 32'd30;
    if (a[9])  d = d + 32'h0001_0000;
    if (a[10]) d = d + 32'd10;
    return d;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      bus_a.cp_damage <= '0;
      bus_b.cp_damage <= '0;
    end else begin
      bus_a.cp_damage <= dmg(bus_a.cp_attack);
      bus_b.cp_damage <= dmg(bus_b.cp_attack);
    end
  end

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] @%0t: got %0h expected %0h", nm, id, $time, act, exp);
    end
  endtask

  task automatic exp_grant(input int id, input logic p2, input logic [31:0] cp);
    gexp_t g;
    g.p2 = p2; g.cp = cp;
    if (id == 0) gqa.push_back(g); else gqb.push_back(g);
  endtask

  task automatic exp_hit(input int id, input logic p2, input logic [9:0] pct);
    hexp_t h;
    h.p2 = p2; h.pct = pct;
    if (id == 0) hqa.push_back(h); else hqb.push_back(h);
  endtask

  task automatic mon_step(input int id, input logic g1, input logic g2, input logic h1,
                          input logic h2, input logic [31:0] cp, input logic [9:0] p1,
                          input logic [9:0] p2);
    gexp_t ge;
    hexp_t he;
    bit    empty;
    if (g1 | g2) begin
      empty = 0;
      if (id == 0) begin if (gqa.size() == 0) empty = 1; else ge = gqa.pop_front(); end
      else         begin if (gqb.size() == 0) empty = 1; else ge = gqb.pop_front(); end
      if (empty) chk("unexpected_grant", id, {g1, g2}, 0);
      else begin
        chk("grant_who", id, {g1, g2}, {~ge.p2, ge.p2});
        chk("grant_cp_attack", id, cp, ge.cp);
      end
    end
    if (h1 | h2) begin
      empty = 0;
      if (id == 0) begin if (hqa.size() == 0) empty = 1; else he = hqa.pop_front(); end
      else         begin if (hqb.size() == 0) empty = 1; else he = hqb.pop_front(); end
      if (empty) chk("unexpected_hit", id, {h1, h2}, 0);
      else begin
        chk("hit_who", id, {h1, h2}, {~he.p2, he.p2});
        chk("hit_percent", id, he.p2 ? p2 : p1, he.pct);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      mon_step(0, bus_a.grant_p1, bus_a.grant_p2, bus_a.hit_p1, bus_a.hit_p2,
               bus_a.cp_attack, bus_a.percent_p1, bus_a.percent_p2);
      mon_step(1, bus_b.grant_p1, bus_b.grant_p2, bus_b.hit_p1, bus_b.hit_p2,
               bus_b.cp_attack, bus_b.percent_p1, bus_b.percent_p2);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_a.req_p1 = 0; bus_a.req_p2 = 0; bus_a.attack_p1 = 0; bus_a.attack_p2 = 0;
    bus_a.clear_percent = 0;
    bus_b.req_p1 = 0; bus_b.req_p2 = 0; bus_b.attack_p1 = 0; bus_b.attack_p2 = 0;
    bus_b.clear_percent = 0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pulses", 0, {bus_a.grant_p1, bus_a.grant_p2, bus_a.hit_p1, bus_a.hit_p2, bus_a.busy}, 0);
    chk("rst_cp_pct", 0, {bus_a.cp_attack, bus_a.percent_p1, bus_a.percent_p2}, 0);
    chk("rst_pulses", 1, {bus_b.grant_p1, bus_b.grant_p2, bus_b.hit_p1, bus_b.hit_p2, bus_b.busy}, 0);
    chk("rst_cp_pct", 1, {bus_b.cp_attack, bus_b.percent_p1, bus_b.percent_p2}, 0);
    rst = 1'b0;

    // B: both requests held, P1 wins the first tie, then strict alternation
    exp_grant(1, 0, 32'h41); exp_grant(1, 1, 32'h81); exp_grant(1, 0, 32'h41);
    exp_hit(1, 1, 10'd10);   exp_hit(1, 0, 10'd15);   exp_hit(1, 1, 10'd20);
    bus_b.attack_p1 = 32'h41; bus_b.attack_p2 = 32'h81;
    bus_b.req_p1 = 1; bus_b.req_p2 = 1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    bus_b.req_p1 = 0; bus_b.req_p2 = 0;
    repeat (4) @(negedge clk);
    chk("alt_pct_p1", 1, bus_b.percent_p1, 15);
    chk("alt_pct_p2", 1, bus_b.percent_p2, 20);
    chk("alt_idle_busy", 1, bus_b.busy, 0);

    // B: clear, then saturation at MAX_PERCENT=40
    bus_b.clear_percent = 1;
    @(negedge clk);
    bus_b.clear_percent = 0;
    chk("clear_p1", 1, bus_b.percent_p1, 0);
    chk("clear_p2", 1, bus_b.percent_p2, 0);
    exp_grant(1, 1, 32'h101); exp_grant(1, 1, 32'h101);
    exp_hit(1, 0, 10'd30);    exp_hit(1, 0, 10'd40);
    bus_b.attack_p2 = 32'h101; bus_b.req_p2 = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus_b.req_p2 = 0;
    repeat (4) @(negedge clk);
    chk("sat40_p1", 1, bus_b.percent_p1, 40);
    bus_b.clear_percent = 1;
    @(negedge clk);
    bus_b.clear_percent = 0;
    chk("clear_after_sat", 1, bus_b.percent_p1, 0);

    // B: clear in the capture cycle wins, hit still pulses
    exp_grant(1, 1, 32'h101); exp_hit(1, 0, 10'd0);
    bus_b.req_p2 = 1;
    @(posedge clk);
    @(negedge clk);
    bus_b.req_p2 = 0;
    @(negedge clk);
    bus_b.clear_percent = 1;
    @(negedge clk);
    bus_b.clear_percent = 0;
    repeat (2) @(negedge clk);
    chk("clear_vs_capture", 1, bus_b.percent_p1, 0);

    // A: single hit, latency and busy
    exp_grant(0, 0, 32'h21); exp_hit(0, 1, 10'd5);
    bus_a.attack_p1 = 32'h21; bus_a.req_p1 = 1;
    @(posedge clk);
    @(negedge clk);
    bus_a.req_p1 = 0;
    chk("t1_busy", 0, bus_a.busy, 1);
    repeat (2) @(negedge clk);
    chk("t3_busy", 0, bus_a.busy, 0);
    chk("t3_cp_attack", 0, bus_a.cp_attack, 0);
    chk("t3_pct_p2", 0, bus_a.percent_p2, 5);

    // A: cooldown blocks a back-to-back hit, then expires
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_pct_p2", 0, bus_a.percent_p2, 0);
    exp_grant(0, 0, 32'h401); exp_grant(0, 0, 32'h0); exp_hit(0, 1, 10'd10);
    bus_a.attack_p1 = 32'h401; bus_a.req_p1 = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus_a.req_p1 = 0;
    repeat (2) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("cd_pct_p2", 0, bus_a.percent_p2, 10);
    exp_grant(0, 0, 32'h401); exp_hit(0, 1, 10'd20);
    bus_a.req_p1 = 1;
    @(posedge clk);
    @(negedge clk);
    bus_a.req_p1 = 0;
    repeat (3) @(negedge clk);
    chk("cd_expired_pct_p2", 0, bus_a.percent_p2, 20);

    // A: invalid attack still handshakes, no damage
    exp_grant(0, 0, 32'h0);
    bus_a.attack_p1 = 32'h20; bus_a.req_p1 = 1;
    @(posedge clk);
    @(negedge clk);
    bus_a.req_p1 = 0;
    repeat (3) @(negedge clk);
    chk("invalid_pct_p2", 0, bus_a.percent_p2, 20);

    // A: reset during ISSUE aborts, no hit follows
    exp_grant(0, 0, 32'h21);
    bus_a.attack_p1 = 32'h21; bus_a.req_p1 = 1;
    @(posedge clk);
    @(negedge clk);
    bus_a.req_p1 = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 0, bus_a.busy, 0);
    chk("abort_cp_grant", 0, {bus_a.cp_attack, bus_a.grant_p1}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pcts", 0, {bus_a.percent_p1, bus_a.percent_p2}, 0);

    // A: upper damage bits force MAX_PERCENT=999
    exp_grant(0, 1, 32'h201); exp_hit(0, 0, 10'd999);
    bus_a.attack_p2 = 32'h201; bus_a.req_p2 = 1;
    @(posedge clk);
    @(negedge clk);
    bus_a.req_p2 = 0;
    repeat (3) @(negedge clk);
    chk("sat999_p1", 0, bus_a.percent_p1, 999);

    repeat (2) @(negedge clk);
    chk("grants_outstanding", 0, gqa.size(), 0);
    chk("hits_outstanding", 0, hqa.size(), 0);
    chk("grants_outstanding", 1, gqb.size(), 0);
    chk("hits_outstanding", 1, hqb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
